// File: rtl/instr_encoder_loader.sv
// Encodes R/addi/sw/lw field bundles into 32-bit words and writes them sequentially to imem.
// Latency: accept -> imem write one cycle later, one word per cycle; in_ready drops after the stopping accept.
module instr_encoder_loader #(
    parameter int ADDR_W    = 12,
    parameter int DEPTH     = 4096,
    parameter int BASE_ADDR = 0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_kind,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_shamt,
    input  logic [4:0]        in_aluop,
    input  logic [16:0]       in_imm,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_data,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [ADDR_W:0]   DEPTH_C  = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W-1:0] BASE_C   = BASE_ADDR[ADDR_W-1:0];
    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t          state;
    logic            stop_pending;
    logic [ADDR_W:0] acc_cnt;   // legal bundles accepted this session (written + pending)
    logic            accept;
    logic            legal;
    logic            stop_now;
    logic [31:0]     enc;

    assign accept   = in_valid & in_ready;
    assign legal    = (in_kind != 2'd0) || (in_aluop <= 5'd5);
    assign stop_now = in_last || (legal && ((acc_cnt + CNT_ONE) == DEPTH_C));

    always_comb begin
        enc = 32'd0;
        case (in_kind)
            2'd0:    enc = {5'b00000, in_rd, in_rs, in_rt, in_shamt, in_aluop, 2'b00};
            2'd1:    enc = {5'b00101, in_rd, in_rs, in_imm};
            2'd2:    enc = {5'b00111, in_rd, in_rs, in_imm};
            default: enc = {5'b01000, in_rd, in_rs, in_imm};
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            stop_pending <= 1'b0;
            acc_cnt      <= '0;
            in_ready     <= 1'b0;
            imem_we      <= 1'b0;
            imem_addr    <= BASE_C;
            imem_data    <= 32'd0;
            done         <= 1'b0;
            err          <= 1'b0;
            word_count   <= '0;
        end else begin
            imem_we <= 1'b0;
            // imem_addr doubles as the write pointer; it advances once the word is out
            if (imem_we) begin
                imem_addr  <= imem_addr + ADDR_ONE;
                word_count <= word_count + CNT_ONE;
            end
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state        <= RUN;
                        stop_pending <= 1'b0;
                        acc_cnt      <= '0;
                        in_ready     <= 1'b1;
                        imem_addr    <= BASE_C;
                        done         <= 1'b0;
                        err          <= 1'b0;
                        word_count   <= '0;
                    end
                end
                RUN: begin
                    if (stop_pending) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        in_ready <= 1'b0;
                    end else if (accept) begin
                        if (legal) begin
                            imem_we   <= 1'b1;
                            imem_data <= enc;
                            acc_cnt   <= acc_cnt + CNT_ONE;
                        end else begin
                            err <= 1'b1;
                        end
                        if (stop_now) begin
                            stop_pending <= 1'b1;
                            in_ready     <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Randomized bench for instr_encoder_loader: session-level reference model plus directed vectors.
module tb_instr_encoder_loader;

    localparam int AW   = 6;
    localparam int DEP  = 16;
    localparam int BASE = 4;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    in_kind = 2'd0;
    logic [4:0]    in_rd = 5'd0, in_rs = 5'd0, in_rt = 5'd0, in_shamt = 5'd0, in_aluop = 5'd0;
    logic [16:0]   in_imm = 17'd0;
    logic          in_last = 1'b0;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_data;
    logic          done;
    logic          err;
    logic [AW:0]   word_count;

    instr_encoder_loader #(.ADDR_W(AW), .DEPTH(DEP), .BASE_ADDR(BASE)) dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
        .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt), .in_shamt(in_shamt),
        .in_aluop(in_aluop), .in_imm(in_imm), .in_last(in_last),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_data(imem_data),
        .done(done), .err(err), .word_count(word_count)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state, expressed in session terms
    bit          m_run, m_stop, m_err, exp_we;
    int          m_since, m_written, m_wc, exp_addr;
    logic [31:0] exp_data;
    logic [31:0] got_q[$];

    function automatic bit ref_legal(input int kind, input int op);
        return (kind != 0) || (op < 6);
    endfunction

    function automatic logic [31:0] ref_enc(input int kind, input int rd, input int rs, input int rt,
                                            input int sh, input int op, input int imm);
        int unsigned w;
        int unsigned opc;
        if (kind == 0) begin
            w = rd * (1 << 22) + rs * (1 << 17) + rt * (1 << 12) + sh * (1 << 7) + op * 4;
        end else begin
            opc = (kind == 1) ? 5 : (kind == 2) ? 7 : 8;
            w = opc * (1 << 27) + rd * (1 << 22) + rs * (1 << 17) + imm;
        end
        return w;
    endfunction

    task automatic model_reset();
        m_run = 0; m_stop = 0; m_err = 0; exp_we = 0;
        m_since = 0; m_written = 0; m_wc = 0; exp_addr = 0; exp_data = 0;
    endtask

    task automatic check_reset(input string pfx);
        check({pfx, "_in_ready"}, in_ready, 0);
        check({pfx, "_imem_we"}, imem_we, 0);
        check({pfx, "_done"}, done, 0);
        check({pfx, "_err"}, err, 0);
        check({pfx, "_imem_addr"}, imem_addr, BASE);
        check({pfx, "_imem_data"}, imem_data, 0);
        check({pfx, "_word_count"}, word_count, 0);
    endtask

    // One clock: check outputs against the model, then drive the next inputs
    task automatic step(input bit st, input bit v, input int k, input int rd, input int rs,
                        input int rt, input int sh, input int op, input int imm, input bit last);
        @(negedge clock);
        if (m_stop) m_since++;
        check("imem_we", imem_we, exp_we);
        if (exp_we) begin
            check("imem_data", imem_data, exp_data);
            check("imem_addr", imem_addr, exp_addr);
            got_q.push_back(imem_data);
        end
        check("word_count", word_count, m_wc);
        if (exp_we) m_wc++;
        check("in_ready", in_ready, m_run && !m_stop);
        check("done", done, m_stop && m_since >= 2);
        check("err", err, m_err);

        start = st; in_valid = v; in_kind = 2'(k); in_rd = 5'(rd); in_rs = 5'(rs);
        in_rt = 5'(rt); in_shamt = 5'(sh); in_aluop = 5'(op); in_imm = 17'(imm); in_last = last;

        exp_we = 0;
        if (v && m_run && !m_stop) begin
            if (ref_legal(k, op)) begin
                exp_we   = 1;
                exp_data = ref_enc(k, rd, rs, rt, sh, op, imm);
                exp_addr = BASE + m_written;
                m_written++;
            end else begin
                m_err = 1;
            end
            if (last || m_written == DEP) begin
                m_stop  = 1;
                m_since = 0;
            end
        end else if (st && (!m_run || (m_stop && m_since >= 2))) begin
            m_run = 1; m_stop = 0; m_err = 0; m_written = 0; m_wc = 0;
            got_q.delete();
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic send(input int k, input int rd, input int rs, input int rt, input int sh,
                        input int op, input int imm, input bit last);
        step(0, 1, k, rd, rs, rt, sh, op, imm, last);
    endtask

    task automatic begin_session();
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        @(negedge clock);
        check_reset("rst");
        @(negedge clock);
        reset_n = 1'b1;
        idle(2);

        // Directed encodings, back to back, last on the fourth
        begin_session();
        send(0, 3, 1, 2, 0, 0, 0, 0);
        send(1, 1, 0, 9, 3, 7, 5, 0);
        send(2, 4, 2, 0, 0, 0, 8, 0);
        send(3, 5, 0, 0, 0, 0, 17'h1FFFF, 1);
        idle(4);
        check("dir_count", got_q.size(), 4);
        if (got_q.size() == 4) begin
            check("dir_r_add", got_q[0], 32'h00C22000);
            check("dir_addi", got_q[1], 32'h28400005);
            check("dir_sw", got_q[2], 32'h39040008);
            check("dir_lw", got_q[3], 32'h4141FFFF);
        end
        check("dir_word_count", word_count, 4);

        // Illegal R aluop between two legal bundles
        begin_session();
        send(1, 2, 3, 0, 0, 0, 100, 0);
        send(0, 1, 1, 1, 0, 31, 0, 0);
        send(0, 7, 6, 5, 4, 5, 0, 1);
        idle(4);
        check("ill_count", got_q.size(), 2);
        check("ill_err", err, 1);
        check("ill_word_count", word_count, 2);

        // Depth limit with no last, including a start pulse mid-run
        begin_session();
        for (int i = 0; i < DEP + 4; i++) begin
            step(i == 3, 1, i % 4, i, i + 1, i + 2, i + 3, i % 6, i * 3, 0);
        end
        idle(3);
        check("depth_count", got_q.size(), DEP);
        check("depth_done", done, 1);
        check("depth_word_count", word_count, DEP);

        // Reset one cycle after an accept drops the pending write
        begin_session();
        send(1, 9, 9, 0, 0, 0, 77, 0);
        @(negedge clock);
        reset_n = 1'b0;
        in_valid = 1'b0;
        #1;
        check_reset("mid_rst");
        @(negedge clock);
        check_reset("mid_rst_hold");
        reset_n = 1'b1;
        model_reset();
        idle(2);

        // Randomized sessions
        for (int s = 0; s < 30; s++) begin
            int cyc;
            begin_session();
            cyc = 0;
            while (!(m_stop && m_since >= 2) && cyc < 200) begin
                bit v, st, last;
                int k, op;
                v    = ($urandom_range(0, 9) < 7);
                st   = ($urandom_range(0, 15) == 0);
                last = ($urandom_range(0, 11) == 0);
                k    = $urandom_range(0, 3);
                op   = $urandom_range(0, 7);
                step(st, v, k, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                     $urandom_range(0, 31), op, $urandom_range(0, 17'h1FFFF), last);
                cyc++;
            end
            check("rnd_session_done", done, 1);
            check("rnd_writes", got_q.size(), m_written);
            idle($urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
